seg_fade_sequencer: RTL
=======================

Name: seg_fade_sequencer

Overview:
Step scheduler for the 7-segment fade/PWM chaser datapath. Generates the step timebase and the segment-decay tick, and walks a selectable segment pattern. On each step it issues one "load segment to level" command to the fade datapath over a valid/ready handshake. The block owns all sequencing; the datapath only stores levels, decays them on decay_tick, and runs PWM.

Parameters:
PRESCALE_WIDTH, 22, step prescaler width; must be >= 4.
DECAY_WIDTH, 22, decay-tick counter width.
FADE_WIDTH, 4, brightness level width; full level = all ones.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
enable  input  1  run sequencer; low forces IDLE
speed  input  3  step rate; 7 = fastest
direction  input  1  1 = forward, 0 = reverse (modes 0, 1)
mode  input  2  0 figure-eight, 1 circle, 2 bounce, 3 flash
cmd_valid  output  1  command valid
cmd_ready  input  1  datapath accepts command
cmd_seg  output  3  segment index 0..6; 7 = broadcast to all segments
cmd_level  output  FADE_WIDTH  level to load
decay_tick  output  1  one-cycle decay strobe
step_idx  output  3  current pattern position
busy  output  1  state != IDLE

Behaviour:
- Reset values: cmd_valid=0, cmd_seg=0, cmd_level=0, decay_tick=0, step_idx=0, busy=0, state=IDLE, both counters 0.
- FSM states: IDLE, RUN, ISSUE.
  - IDLE: counters held at 0, step_idx=0. When enable=1, go to ISSUE with step_idx=0; first command appears on the next cycle.
  - RUN: step counter increments each cycle. Step terminal = {~speed, (PRESCALE_WIDTH-3) ones}; step period = terminal+1 cycles. At terminal: counter goes to 0, step_idx advances, state goes to ISSUE.
  - ISSUE: cmd_valid=1, cmd_seg/cmd_level registered and stable until cmd_valid&&cmd_ready, then return to RUN. Step counter is frozen during ISSUE, so steps are neither lost nor doubled. Back-to-back handshake allowed (ready already high gives 1-cycle ISSUE).
- enable low in any state: next cycle state=IDLE, cmd_valid=0 (command abandoned; the datapath tolerates this), counters cleared.
- Patterns (cmd_seg by step_idx):
  - mode 0, length 8: 0,1,6,4,3,2,6,5.
  - mode 1, length 6: 0,1,2,3,4,5.
  - mode 2: ping-pong over 0..5 (0,1,2,3,4,5,4,3,2,1,0,1...). Uses an internal bounce_dir that flips at 0 and 5; direction input ignored.
  - mode 3, length 2: cmd_seg=7; idx0 level=full, idx1 level=0.
- Modes 0-2 drive cmd_level = full.
- direction=1: idx+1 mod length; direction=0: idx-1 mod length (0 wraps to length-1).
- Mode change is sampled only at step events. If the current idx >= new length, the next idx is 0; bounce_dir resets to up.
- speed and direction are sampled at step events only.
- decay_tick: DECAY_WIDTH counter free-runs while state != IDLE. decay_tick=1 for the cycle in which the counter equals all ones, then the counter wraps. It is independent of the handshake.

Optional Feature:
SEQ_LFSR_EN:
- Defined: mode 3 becomes random sparkle. An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset and on IDLE entry) advances once per step event. cmd_seg = lfsr[2:0], with 7 mapped to 0; level = full.
- Undefined: mode 3 is broadcast flash as above, and no LFSR flops exist.

Decomposition:
- Package seg_seq_pkg holds:
  - state enum (IDLE/RUN/ISSUE);
  - mode enum;
  - pattern length constants (8, 6, 6, 2);
  - figure-eight ROM constant;
  - SEG_ALL=3'd7;
  - LFSR seed and taps.
- Sub-module seg_seq_timer holds the step prescaler (terminal compare, freeze input, clear input) and the decay counter/strobe. The top holds the FSM, pattern walk and handshake register.

Test Plan:
- Bench settings: PRESCALE_WIDTH=6, DECAY_WIDTH=4, FADE_WIDTH=4.
- Reset and start: reset_n low mid-ISSUE -> all outputs 0 immediately. Release, enable=1, mode 0, cmd_ready=1 -> first handshake cmd_seg=0, level=4'hF, 2 cycles after enable rises.
- Speed/order: speed=7, direction=1, ready=1 -> handshakes every 9 cycles (8 count + 1 ISSUE), cmd_seg sequence 0,1,6,4,3,2,6,5,0.
- Backpressure: hold cmd_ready=0 for 20 cycles during ISSUE -> cmd_valid, cmd_seg and cmd_level stable, step counter frozen, no skipped idx after release.
- Reverse/bounce wrap: mode 1, direction=0 from idx0 -> 5,4,...; mode 2 -> 0,1,2,3,4,5,4,3 regardless of direction.
- Mode switch clamp: at idx 7 in mode 0, switch to mode 1 -> next cmd_seg=0. Mode 3 -> cmd_seg=7 with levels F,0,F alternating.
- decay_tick: enable=1 -> single-cycle pulse every 16 cycles, continues while cmd_ready=0. enable=0 -> no pulses, busy=0 the next cycle.

Source files
------------

// File: rtl/seg_seq_pkg.sv
// Shared types and constants for the 7-segment fade sequencer: FSM/mode enums,
// pattern lengths, figure-eight segment order and the sparkle LFSR polynomial.
package seg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_FIG8   = 2'd0,
        MODE_CIRCLE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FLASH  = 2'd3
    } seq_mode_e;

    localparam logic [3:0] LEN_FIG8   = 4'd8;
    localparam logic [3:0] LEN_CIRCLE = 4'd6;
    localparam logic [3:0] LEN_BOUNCE = 4'd6;
    localparam logic [3:0] LEN_FLASH  = 4'd2;
    localparam logic [2:0] BOUNCE_TOP = 3'd5;

    localparam logic [2:0] FIG8_ROM [0:7] = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd6, 3'd5};
    localparam logic [2:0] SEG_ALL = 3'd7;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] pattern_len(input seq_mode_e m);
        case (m)
            MODE_FIG8:   pattern_len = LEN_FIG8;
            MODE_CIRCLE: pattern_len = LEN_CIRCLE;
            MODE_BOUNCE: pattern_len = LEN_BOUNCE;
            default:     pattern_len = LEN_FLASH;
        endcase
    endfunction

    function automatic logic [2:0] pattern_seg(input seq_mode_e m, input logic [2:0] idx);
        case (m)
            MODE_FIG8: pattern_seg = FIG8_ROM[idx];
            MODE_FLASH: pattern_seg = SEG_ALL;
            default:   pattern_seg = idx;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        lfsr_next = {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/seg_fade_sequencer_if.sv
// Command channel from the sequencer to the fade datapath: one "load segment to
// level" command per valid/ready handshake.
interface seg_fade_sequencer_if #(
    parameter int FADE_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_seg;
    logic [FADE_WIDTH-1:0] cmd_level;

    modport master (output cmd_valid, output cmd_seg, output cmd_level, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_seg, input cmd_level, output cmd_ready);
endinterface

// File: rtl/seg_seq_timer.sv
// Step prescaler (speed-dependent terminal, freeze while a command is pending)
// and free-running decay counter with a one-cycle strobe at all-ones.
module seg_seq_timer
    import seg_seq_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 22,
    parameter int DECAY_WIDTH    = 22
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       freeze,
    input  logic [2:0] speed,
    output logic       step_hit,
    output logic       decay_tick
);
    localparam int LOW_W = PRESCALE_WIDTH - 3;

    logic [PRESCALE_WIDTH-1:0] step_cnt_q, step_cnt_d, step_term;
    logic [DECAY_WIDTH-1:0]    decay_cnt_q, decay_cnt_d;

    // Higher speed code shrinks the top bits of the terminal count
    assign step_term  = {~speed, {LOW_W{1'b1}}};
    assign step_hit   = !clr && !freeze && (step_cnt_q == step_term);
    assign decay_tick = (decay_cnt_q == {DECAY_WIDTH{1'b1}});

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (clr) begin
            step_cnt_d = '0;
        end else if (!freeze) begin
            step_cnt_d = step_hit ? '0 : step_cnt_q + 1'b1;
        end
        decay_cnt_d = clr ? '0 : decay_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            step_cnt_q  <= step_cnt_d;
            decay_cnt_q <= decay_cnt_d;
        end
    end
endmodule

// File: rtl/seg_fade_sequencer.sv
// Step scheduler for the 7-segment fade chaser: FSM, pattern walk and command register.
// Build option SEQ_LFSR_EN turns mode 3 into an LFSR-driven random sparkle.
module seg_fade_sequencer
    import seg_seq_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 22,
    parameter int DECAY_WIDTH    = 22,
    parameter int FADE_WIDTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [2:0]                  speed,
    input  logic                        direction,
    input  logic [1:0]                  mode,
    seg_fade_sequencer_if.master        cmd_if,
    output logic                        decay_tick,
    output logic [2:0]                  step_idx,
    output logic                        busy
);
    localparam logic [FADE_WIDTH-1:0] LEVEL_FULL = '1;

    seq_state_e            state_q, state_d;
    seq_mode_e             mode_q, mode_d, mode_in;
    logic [2:0]            idx_q, idx_d, idx_step, pat_idx, pat_seg;
    logic [2:0]            speed_q, speed_d;
    logic                  bounce_up_q, bounce_up_d, bounce_step, up, mode_chg;
    logic [3:0]            len;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [2:0]            cmd_seg_q, cmd_seg_d;
    logic [FADE_WIDTH-1:0] cmd_level_q, cmd_level_d, pat_lvl;
    logic                  step_hit, timer_clr;
`ifdef SEQ_LFSR_EN
    logic [7:0]            lfsr_q, lfsr_d, pat_lfsr;
`endif

    assign timer_clr = (state_q == ST_IDLE) || !enable;

    seg_seq_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .DECAY_WIDTH    (DECAY_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (timer_clr),
        .freeze     (state_q == ST_ISSUE),
        .speed      (speed_q),
        .step_hit   (step_hit),
        .decay_tick (decay_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_ISSUE;
                ST_RUN:   if (step_hit) state_d = ST_ISSUE;
                ST_ISSUE: if (cmd_if.cmd_ready) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next pattern position for a step event, using the mode sampled at that step
    always_comb begin : step_calc
        mode_in     = seq_mode_e'(mode);
        len         = pattern_len(mode_in);
        mode_chg    = (mode_in != mode_q);
        up          = mode_chg ? 1'b1 : bounce_up_q;
        idx_step    = idx_q;
        bounce_step = up;
        if (mode_chg && ({1'b0, idx_q} >= len)) begin
            idx_step    = '0;
            bounce_step = 1'b1;
        end else if (mode_in == MODE_BOUNCE) begin
            if (up) begin
                if (idx_q == BOUNCE_TOP) begin
                    idx_step    = idx_q - 3'd1;
                    bounce_step = 1'b0;
                end else begin
                    idx_step = idx_q + 3'd1;
                end
            end else if (idx_q == 3'd0) begin
                idx_step    = 3'd1;
                bounce_step = 1'b1;
            end else begin
                idx_step = idx_q - 3'd1;
            end
        end else if (direction) begin
            idx_step = (({1'b0, idx_q} + 4'd1) == len) ? 3'd0 : idx_q + 3'd1;
        end else begin
            idx_step = (idx_q == 3'd0) ? 3'(len - 4'd1) : idx_q - 3'd1;
        end
    end

    always_comb begin : pattern_sel
        pat_idx = (state_q == ST_IDLE) ? 3'd0 : idx_step;
`ifdef SEQ_LFSR_EN
        pat_lfsr = (state_q == ST_IDLE) ? lfsr_q : lfsr_next(lfsr_q);
`endif
        pat_seg = pattern_seg(mode_in, pat_idx);
        pat_lvl = LEVEL_FULL;
        if (mode_in == MODE_FLASH) begin
`ifdef SEQ_LFSR_EN
            pat_seg = (pat_lfsr[2:0] == SEG_ALL) ? 3'd0 : pat_lfsr[2:0];
`else
            if (pat_idx[0]) pat_lvl = '0;
`endif
        end
    end

    always_comb begin : fsm_outputs
        idx_d       = idx_q;
        mode_d      = mode_q;
        speed_d     = speed_q;
        bounce_up_d = bounce_up_q;
        cmd_valid_d = cmd_valid_q;
        cmd_seg_d   = cmd_seg_q;
        cmd_level_d = cmd_level_q;
`ifdef SEQ_LFSR_EN
        lfsr_d      = lfsr_q;
`endif
        if (!enable) begin
            // A pending command is simply dropped; the datapath tolerates it
            idx_d       = '0;
            bounce_up_d = 1'b1;
            cmd_valid_d = 1'b0;
            cmd_seg_d   = '0;
            cmd_level_d = '0;
`ifdef SEQ_LFSR_EN
            lfsr_d      = LFSR_SEED;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d       = '0;
                    mode_d      = mode_in;
                    speed_d     = speed;
                    bounce_up_d = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_seg_d   = pat_seg;
                    cmd_level_d = pat_lvl;
                end
                ST_RUN: begin
                    if (step_hit) begin
                        idx_d       = idx_step;
                        mode_d      = mode_in;
                        speed_d     = speed;
                        bounce_up_d = bounce_step;
                        cmd_valid_d = 1'b1;
                        cmd_seg_d   = pat_seg;
                        cmd_level_d = pat_lvl;
`ifdef SEQ_LFSR_EN
                        lfsr_d      = pat_lfsr;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (cmd_if.cmd_ready) cmd_valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            mode_q      <= MODE_FIG8;
            speed_q     <= '0;
            bounce_up_q <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_seg_q   <= '0;
            cmd_level_q <= '0;
`ifdef SEQ_LFSR_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            bounce_up_q <= bounce_up_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_seg_q   <= cmd_seg_d;
            cmd_level_q <= cmd_level_d;
`ifdef SEQ_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_seg   = cmd_seg_q;
    assign cmd_if.cmd_level = cmd_level_q;
    assign step_idx         = idx_q;
    assign busy             = (state_q != ST_IDLE);
endmodule
